// File: rtl/param_ping_pong_counter.sv
// param_ping_pong_counter: up/down sweep between run-time bounds with flip, load and bounce pulse
module param_ping_pong_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flip,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] min,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             direction,
  output logic [WIDTH-1:0] out,
  output logic             bounce
);
  logic             d;
  logic             valid;
  logic             step;
  logic             at_max;
  logic             at_min;
  logic             dir_nx;
  logic             bounce_nx;
  logic [WIDTH-1:0] out_nx;
  always_comb begin
    d         = direction ^ flip;
    valid     = (max > min) && (out >= min) && (out <= max);
    step      = !load && enable && valid;
    at_max    = d && (out == max);
    at_min    = !d && (out == min);
    bounce_nx = step && (at_max || at_min);
    dir_nx    = !step ? direction : at_max ? 1'b0 : at_min ? 1'b1 : d;
    out_nx    = load ? load_val :
                !step ? out :
                at_max ? max - WIDTH'(1) :
                at_min ? min + WIDTH'(1) :
                d ? out + WIDTH'(1) : out - WIDTH'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      direction <= 1'b1;
      bounce    <= 1'b0;
    end else begin
      out       <= out_nx;
      direction <= dir_nx;
      bounce    <= bounce_nx;
    end
  end
endmodule

// File: tb/tb_param_ping_pong_counter.sv
// tb_param_ping_pong_counter: directed plan plus random run against a reflective sweep model
module tb_param_ping_pong_counter;
  localparam int W = 4;
  logic         clk = 0;
  logic         rst_n;
  logic         enable;
  logic         flip;
  logic [W-1:0] max;
  logic [W-1:0] min;
  logic         load;
  logic [W-1:0] load_val;
  logic         direction;
  logic [W-1:0] out;
  logic         bounce;
  int passed = 0;
  int total  = 0;
  bit cmp_en = 0;
  int m_out;
  bit m_dir;
  bit m_bnc;
  int s_out;
  bit s_dir;
  bit s_bnc;

  param_ping_pong_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flip(flip), .max(max), .min(min),
    .load(load), .load_val(load_val), .direction(direction), .out(out), .bounce(bounce)
  );

  always #5 clk = ~clk;

  // Model: take a tentative step; if it overshoots the range, reflect back off the bound.
  always_comb begin
    int dl;
    int nx;
    s_out = m_out;
    s_dir = m_dir;
    s_bnc = 0;
    dl    = (m_dir ^ flip) ? 1 : -1;
    nx    = m_out + dl;
    if (load) s_out = int'(load_val);
    else if (enable && int'(max) > int'(min) && m_out >= int'(min) && m_out <= int'(max)) begin
      if (nx > int'(max) || nx < int'(min)) begin
        s_out = m_out - dl;
        s_dir = (dl < 0);
        s_bnc = 1;
      end else begin
        s_out = nx;
        s_dir = (dl > 0);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= 0;
      m_dir <= 1;
      m_bnc <= 0;
    end else begin
      m_out <= s_out;
      m_dir <= s_dir;
      m_bnc <= s_bnc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_out", int'(out), m_out);
      chk("model_dir", int'(direction), int'(m_dir));
      chk("model_bounce", int'(bounce), int'(m_bnc));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int seq[8];
    int bnc[8];
    seq = '{3, 4, 5, 6, 5, 4, 3, 4};
    bnc = '{0, 0, 0, 0, 1, 0, 0, 1};
    rst_n = 0; enable = 0; flip = 0; load = 0; load_val = 0; min = 0; max = 15;
    tick(2);
    chk("reset_out", int'(out), 0);
    chk("reset_dir", int'(direction), 1);
    chk("reset_bounce", int'(bounce), 0);
    rst_n = 1; enable = 1; cmp_en = 1;
    tick(15);
    chk("full_top_out", int'(out), 15);
    chk("full_top_dir", int'(direction), 1);
    tick();
    chk("full_bounce_out", int'(out), 14);
    chk("full_bounce_dir", int'(direction), 0);
    chk("full_bounce_pulse", int'(bounce), 1);
    tick();
    chk("full_pulse_one_cycle", int'(bounce), 0);
    tick(13);
    chk("full_bottom_out", int'(out), 0);
    tick();
    chk("full_rebound_out", int'(out), 1);
    chk("full_rebound_dir", int'(direction), 1);
    chk("full_rebound_pulse", int'(bounce), 1);
    // enable gating, with flip asserted only while disabled
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 64; i++) begin
      enable = (i % 2 == 0);
      flip = !enable;
      tick();
      if (i == 29) begin
        chk("gated_out30", int'(out), 15);
        chk("gated_dir30", int'(direction), 1);
      end
    end
    flip = 0; enable = 1;
    // narrow range sweep
    min = 3; max = 6; load = 1; load_val = 3;
    tick();
    load = 0;
    chk("narrow_seq0", int'(out), seq[0]);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("narrow_seq%0d", i), int'(out), seq[i]);
      chk($sformatf("narrow_bnc%0d", i), int'(bounce), bnc[i]);
    end
    tick();
    chk("pre_flip_out", int'(out), 5);
    flip = 1;
    tick();
    flip = 0;
    chk("flip_out", int'(out), 4);
    chk("flip_dir", int'(direction), 0);
    // degenerate and inverted ranges freeze
    min = 8; max = 8;
    tick(3);
    chk("eq_range_out", int'(out), 4);
    chk("eq_range_bounce", int'(bounce), 0);
    min = 10; max = 5;
    tick(3);
    chk("inv_range_out", int'(out), 4);
    min = 0; max = 15;
    tick();
    chk("range_restored_out", int'(out), 3);
    // out-of-range load freezes, in-range load resumes
    max = 9; load = 1; load_val = 12;
    tick();
    load = 0;
    chk("oor_load_out", int'(out), 12);
    tick(3);
    chk("oor_frozen_out", int'(out), 12);
    load = 1; load_val = 4;
    tick();
    load = 0;
    chk("reload_out", int'(out), 4);
    tick();
    chk("reload_step_out", int'(out), 3);
    // asynchronous reset between edges
    max = 15; load = 1; load_val = 9; enable = 0;
    tick();
    load = 0;
    chk("pre_reset_out", int'(out), 9);
    chk("pre_reset_dir", int'(direction), 0);
    #2 rst_n = 0;
    #1;
    chk("async_reset_out", int'(out), 0);
    chk("async_reset_dir", int'(direction), 1);
    tick();
    rst_n = 1; enable = 1;
    tick();
    chk("post_reset_out", int'(out), 1);
    // randomized run
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom % 500 != 0);
      enable = ($urandom % 8 != 0);
      flip = ($urandom % 10 == 0);
      load = ($urandom % 40 == 0);
      load_val = W'($urandom);
      if ($urandom % 60 == 0) begin
        min = W'($urandom);
        max = W'($urandom);
      end else if ($urandom % 200 == 0) begin
        min = 0;
        max = 15;
      end
      tick();
    end
    cmp_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
